lfsr_cluster_burst: RTL and testbench

Parametrised successor to the fixed 16-core greeble cluster. It holds NUM_CORES Galois-LFSR cores seeded from one shared seed plus a per-core offset, and reduces their per-core contributions each step (XOR, sum or round-robin select). Results stream out over a valid/ready port in bursts of programmable length. It sits between ui_in-style seed sources and the top-level output mixer and replaces free-running per-cycle cores with a controlled, stallable burst engine.

---
 rtl/lfsr_cluster_burst.sv | 185 ++++++++++++++++++
 tb/tb_lfsr_cluster_burst.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_cluster_burst.sv
// Burst engine over NUM_CORES Galois LFSR cores. Per-core contributions are reduced
// (XOR / sum / round-robin select) and streamed out on a valid/ready port.
module lfsr_cluster_burst #(
  parameter int                 NUM_CORES   = 16,
  parameter int                 DATA_W      = 8,
  parameter int                 STATE_W     = 16,
  parameter logic [STATE_W-1:0] POLY        = 16'hB400,
  parameter int                 SEED_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [1:0]        mode,
  input  logic [7:0]        burst_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int KW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              fsm_q, fsm_d;
  logic [STATE_W-1:0]  core_q [NUM_CORES];
  logic [STATE_W-1:0]  core_d [NUM_CORES];
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [1:0]          mode_q, mode_d;
  logic [8:0]          remaining_q, remaining_d;
  logic [KW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                seed_ready_q, seed_ready_d;

  logic [DATA_W-1:0]   contrib_s [NUM_CORES];
  logic [DATA_W-1:0]   red_xor_s, red_sum_s, red_sel_s, reduced_s;

  function automatic logic [DATA_W-1:0] core_seed(input logic [DATA_W-1:0] base, input int idx);
    return base + DATA_W'(SEED_OFFSET + idx);
  endfunction

  // Seed replicated across the state width; an all-zero state would lock the LFSR.
  function automatic logic [STATE_W-1:0] load_value(input logic [DATA_W-1:0] s);
    logic [STATE_W-1:0] v;
    v = '0;
    for (int b = 0; b < STATE_W; b++) begin
      v[b] = s[b % DATA_W];
    end
    if (v == '0) begin
      v = {{(STATE_W-1){1'b0}}, 1'b1};
    end else begin
      v = v;
    end
    return v;
  endfunction

  function automatic logic [STATE_W-1:0] galois_step(input logic [STATE_W-1:0] s);
    if (s[0]) begin
      return (s >> 1) ^ POLY;
    end else begin
      return s >> 1;
    end
  endfunction

  // Per-core contributions and the three reductions of the current states.
  always_comb begin
    red_xor_s = '0;
    red_sum_s = '0;
    red_sel_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      contrib_s[i] = core_q[i][STATE_W-1 -: DATA_W] + core_q[i][DATA_W-1:0] + core_seed(seed_q, i);
      red_xor_s    = red_xor_s ^ contrib_s[i];
      red_sum_s    = red_sum_s + contrib_s[i];
      red_sel_s    = red_sel_s | ((KW'(i) == k_q) ? contrib_s[i] : '0);
    end
    case (mode_q)
      2'd1:    reduced_s = red_sum_s;
      2'd2:    reduced_s = red_sel_s;
      default: reduced_s = red_xor_s;
    endcase
  end

  // Burst FSM next-state: load on seed accept, advance when the output slot is free.
  always_comb begin
    fsm_d       = fsm_q;
    core_d      = core_q;
    seed_d      = seed_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (seed_valid) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            core_d[i] = load_value(core_seed(seed_in, i));
          end
          seed_d      = seed_in;
          mode_d      = mode;
          remaining_d = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
          k_d         = '0;
          fsm_d       = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = reduced_s;
          out_valid_d = 1'b1;
          for (int i = 0; i < NUM_CORES; i++) begin
            core_d[i] = galois_step(core_q[i]);
          end
          k_d         = (k_q == KW'(NUM_CORES - 1)) ? '0 : k_q + KW'(1);
          remaining_d = remaining_q - 9'd1;
          fsm_d       = (remaining_q == 9'd1) ? DRAIN : RUN;
        end else begin
          fsm_d = RUN;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          fsm_d       = IDLE;
        end else begin
          fsm_d = DRAIN;
        end
      end
      default: fsm_d = IDLE;
    endcase
    busy_d       = (fsm_d != IDLE);
    seed_ready_d = (fsm_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= IDLE;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_q[i] <= '0;
      end
      seed_q       <= '0;
      mode_q       <= 2'd0;
      remaining_q  <= 9'd0;
      k_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      seed_ready_q <= 1'b1;
    end else begin
      fsm_q        <= fsm_d;
      core_q       <= core_d;
      seed_q       <= seed_d;
      mode_q       <= mode_d;
      remaining_q  <= remaining_d;
      k_q          <= k_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      seed_ready_q <= seed_ready_d;
    end
  end

  assign seed_ready = seed_ready_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lfsr_cluster_burst.sv
// Bench for lfsr_cluster_burst: 1-, 2- and 16-core instances driven in lockstep,
// directed vector table plus randomized bursts against a queue-free array model.
module tb_lfsr_cluster_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seed_in;
  logic       seed_valid;
  logic [1:0] mode;
  logic [7:0] burst_len;
  logic       out_ready;

  logic [7:0] od [3];
  logic       ov [3];
  logic       sr [3];
  logic       bz [3];
  logic       dn [3];

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_mem [3][256];
  logic [7:0] cap [2][2];

  always #5 clk = ~clk;

  lfsr_cluster_burst #(.NUM_CORES(1)) u1 (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr[0]),
    .mode(mode), .burst_len(burst_len), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .busy(bz[0]), .done(dn[0]));

  lfsr_cluster_burst #(.NUM_CORES(2)) u2 (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr[1]),
    .mode(mode), .burst_len(burst_len), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .busy(bz[1]), .done(dn[1]));

  lfsr_cluster_burst #(.NUM_CORES(16)) u16 (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .seed_ready(sr[2]),
    .mode(mode), .burst_len(burst_len), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .busy(bz[2]), .done(dn[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected results of a whole burst, straight from the core/contribution/reduction rules.
  task automatic fill(input int d, input int nc, input logic [7:0] seed, input logic [1:0] m, input int len);
    logic [15:0] st [64];
    logic [7:0]  s [64];
    logic [7:0]  c;
    logic [7:0]  acc;
    for (int i = 0; i < nc; i++) begin
      s[i]  = seed + 8'(i);
      st[i] = {s[i], s[i]};
      if (st[i] == 16'h0000) st[i] = 16'h0001;
    end
    for (int n = 0; n < len; n++) begin
      acc = 8'h00;
      for (int i = 0; i < nc; i++) begin
        c = st[i][15:8] + st[i][7:0] + s[i];
        if (m == 2'd1) acc = acc + c;
        else if (m == 2'd2) begin
          if (i == n % nc) acc = c;
        end else acc = acc ^ c;
      end
      exp_mem[d][n] = acc;
      for (int i = 0; i < nc; i++) begin
        st[i] = st[i][0] ? ((st[i] >> 1) ^ 16'hB400) : (st[i] >> 1);
      end
    end
  endtask

  task automatic run_burst(input logic [7:0] seed, input logic [1:0] m, input logic [7:0] bl,
                           input int stall_pct, input int forced_stall, input bit noise);
    int nexp, got, cyc_n, first_v, stall_left;
    bit prev_stall;
    logic [7:0] prev_d [3];
    nexp = (bl == 8'd0) ? 256 : int'(bl);
    fill(0, 1, seed, m, nexp);
    fill(1, 2, seed, m, nexp);
    fill(2, 16, seed, m, nexp);
    seed_in = seed; mode = m; burst_len = bl; seed_valid = 1'b1; out_ready = 1'b0;
    chk("seed_ready_idle", sr[2], 1);
    cyc();
    seed_valid = 1'b0;
    got = 0; cyc_n = 0; first_v = -1; prev_stall = 1'b0; stall_left = forced_stall;
    prev_d = od;
    while (got < nexp && cyc_n < nexp * 20 + 50) begin
      if (ov[0] && first_v < 0) first_v = cyc_n;
      if (first_v >= 0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (noise) begin
        seed_valid = 1'($urandom_range(1));
        seed_in    = 8'($urandom);
        mode       = 2'($urandom);
        burst_len  = 8'($urandom);
      end
      chk("busy_in_burst", bz[2], 1);
      chk("seed_ready_in_burst", sr[2], 0);
      chk("no_early_done", dn[2], 0);
      if (prev_stall) begin
        for (int d = 0; d < 3; d++) chk("stall_hold", od[d], prev_d[d]);
        chk("stall_valid", ov[2], 1);
      end
      if (ov[0] && out_ready) begin
        for (int d = 0; d < 3; d++) chk($sformatf("data%0d_n%0d", d, got), od[d], exp_mem[d][got]);
        if (got < 2) begin
          cap[0][got] = od[0];
          cap[1][got] = od[1];
        end
        got++;
      end
      prev_stall = ov[0] && !out_ready;
      prev_d = od;
      cyc();
      cyc_n++;
    end
    seed_valid = 1'b0; out_ready = 1'b0;
    chk("burst_complete", got, nexp);
    chk("first_valid_latency", first_v, 1);
    if (stall_pct == 0 && forced_stall == 0) chk("throughput", cyc_n, nexp + 1);
    for (int d = 0; d < 3; d++) begin
      chk("done_pulse", dn[d], 1);
      chk("valid_cleared", ov[d], 0);
      chk("busy_cleared", bz[d], 0);
    end
    chk("seed_ready_back", sr[2], 1);
    cyc();
    chk("done_cleared", dn[2], 0);
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [1:0] m;
    logic [7:0] bl;
    logic [7:0] e1_0, e1_1, e2_0, e2_1;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{seed: 8'h05, m: 2'd0, bl: 8'd2, e1_0: 8'h0F, e1_1: 8'h3D, e2_0: 8'h1D, e2_1: 8'h31};
    vt[1] = '{seed: 8'h05, m: 2'd1, bl: 8'd1, e1_0: 8'h0F, e1_1: 8'h00, e2_0: 8'h21, e2_1: 8'h00};
    vt[2] = '{seed: 8'h05, m: 2'd3, bl: 8'd1, e1_0: 8'h0F, e1_1: 8'h00, e2_0: 8'h1D, e2_1: 8'h00};
    vt[3] = '{seed: 8'h05, m: 2'd2, bl: 8'd2, e1_0: 8'h0F, e1_1: 8'h3D, e2_0: 8'h0F, e2_1: 8'h0C};
    vt[4] = '{seed: 8'h00, m: 2'd0, bl: 8'd1, e1_0: 8'h01, e1_1: 8'h00, e2_0: 8'h02, e2_1: 8'h00};

    rst = 1'b1; seed_in = 8'h00; seed_valid = 1'b0; mode = 2'd0; burst_len = 8'd1; out_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_busy", bz[d], 0);
      chk("rst_done", dn[d], 0);
      chk("rst_seed_ready", sr[d], 1);
      chk("rst_out_data", od[d], 0);
    end

    for (int v = 0; v < 5; v++) begin
      run_burst(vt[v].seed, vt[v].m, vt[v].bl, 0, 0, 1'b0);
      chk($sformatf("vec%0d_c1_first", v), cap[0][0], vt[v].e1_0);
      chk($sformatf("vec%0d_c2_first", v), cap[1][0], vt[v].e2_0);
      if (vt[v].bl >= 8'd2) begin
        chk($sformatf("vec%0d_c1_second", v), cap[0][1], vt[v].e1_1);
        chk($sformatf("vec%0d_c2_second", v), cap[1][1], vt[v].e2_1);
      end
    end

    // Five stalled cycles on the first result, with seed offers that must be ignored.
    run_burst(8'h05, 2'd0, 8'd4, 0, 5, 1'b1);
    chk("stall_c1_second", cap[0][1], 8'h3D);

    for (int r = 0; r < 12; r++) begin
      run_burst(8'($urandom), 2'($urandom), 8'($urandom_range(40, 1)), 30, 0, 1'b1);
    end

    // Abort mid-burst with 100 results still pending.
    seed_in = 8'h3C; mode = 2'd1; burst_len = 8'd200; seed_valid = 1'b1; out_ready = 1'b1;
    cyc();
    seed_valid = 1'b0;
    repeat (100) cyc();
    chk("pre_abort_valid", ov[2], 1);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("abort_valid", ov[d], 0);
      chk("abort_busy", bz[d], 0);
      chk("abort_done", dn[d], 0);
      chk("abort_data", od[d], 0);
    end
    out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_abort_done", dn[2], 0);
    chk("post_abort_ready", sr[2], 1);

    run_burst(8'hA7, 2'd2, 8'd0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
